// File: rtl/mult4b_seq.sv
// mult4b_seq: 4x4 unsigned sequential shift-and-add multiplier, 8-bit product.
// One operation takes 4 RUN cycles plus a 1-cycle DONE pulse; uses a single 4-bit adder.
`default_nettype none

module adder4b (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [4:0] sum_o
);
  assign sum_o = {1'b0, a_i} + {1'b0, b_i};
endmodule

module mult4b_seq (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] p_o
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0] state_q, state_d;
  logic [3:0] m_q, m_d;
  logic [3:0] ah_q, ah_d;
  logic [3:0] q_q, q_d;
  logic [1:0] cnt_q, cnt_d;
  logic [7:0] p_q, p_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [4:0] sum_w;
  logic [3:0] addend_w;

  assign addend_w = q_q[0] ? m_q : 4'd0;

  adder4b u_adder (
    .a_i   (ah_q),
    .b_i   (addend_w),
    .sum_o (sum_w)
  );

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; the unused encoding falls back to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_RUN;
      S_RUN:   if (cnt_q == 2'd3) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next-value logic
  always_comb begin
    m_d    = m_q;
    ah_d   = ah_q;
    q_d    = q_q;
    cnt_d  = cnt_q;
    p_d    = p_q;
    busy_d = (state_d == S_RUN) || (state_d == S_DONE);
    done_d = (state_d == S_DONE);
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          m_d   = a_i;
          q_d   = b_i;
          ah_d  = 4'd0;
          cnt_d = 2'd0;
        end
      end
      S_RUN: begin
        // {sum,Q} shifted right by one keeps the adder carry in AH[3]
        ah_d  = sum_w[4:1];
        q_d   = {sum_w[0], q_q[3:1]};
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) p_d = {sum_w, q_q[3:1]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_q    <= 4'd0;
      ah_q   <= 4'd0;
      q_q    <= 4'd0;
      cnt_q  <= 2'd0;
      p_q    <= 8'd0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      m_q    <= m_d;
      ah_q   <= ah_d;
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      p_q    <= p_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign p_o    = p_q;
endmodule

`default_nettype wire

// File: tb/tb_mult4b_seq.sv
// tb_mult4b_seq: directed table, multi-cycle corner sequences and an exhaustive sweep.
`default_nettype none

module tb_mult4b_seq;
  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [7:0] p;

  int checks;
  int failures;

  typedef struct {
    logic [3:0] va;
    logic [3:0] vb;
    logic [7:0] exp_p;
  } vec_t;

  vec_t vecs [10];

  mult4b_seq dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .a_i     (a),
    .b_i     (b),
    .busy_o  (busy),
    .done_o  (done),
    .p_o     (p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full single operation with cycle-by-cycle checks from E0 through E5
  task automatic run_op(input logic [3:0] ia, input logic [3:0] ib, input logic [7:0] ep);
    logic [7:0] prev;
    @(negedge clk);
    start = 1'b1;
    a = ia;
    b = ib;
    prev = p;
    tick();
    chk($sformatf("%0d*%0d busy E0", ia, ib), {7'd0, busy}, 8'd1);
    chk($sformatf("%0d*%0d done E0", ia, ib), {7'd0, done}, 8'd0);
    chk($sformatf("%0d*%0d P hold E0", ia, ib), p, prev);
    @(negedge clk);
    start = 1'b0;
    a = ~ia;
    b = ~ib;
    for (int e = 1; e <= 3; e++) begin
      tick();
      chk($sformatf("%0d*%0d busy E%0d", ia, ib, e), {7'd0, busy}, 8'd1);
      chk($sformatf("%0d*%0d done E%0d", ia, ib, e), {7'd0, done}, 8'd0);
      chk($sformatf("%0d*%0d P hold E%0d", ia, ib, e), p, prev);
    end
    tick();
    chk($sformatf("%0d*%0d done E4", ia, ib), {7'd0, done}, 8'd1);
    chk($sformatf("%0d*%0d busy E4", ia, ib), {7'd0, busy}, 8'd1);
    chk($sformatf("%0d*%0d P E4", ia, ib), p, ep);
    tick();
    chk($sformatf("%0d*%0d done E5", ia, ib), {7'd0, done}, 8'd0);
    chk($sformatf("%0d*%0d busy E5", ia, ib), {7'd0, busy}, 8'd0);
    chk($sformatf("%0d*%0d P E5", ia, ib), p, ep);
  endtask

  initial begin
    int dones;
    checks   = 0;
    failures = 0;
    rst   = 1'b1;
    start = 1'b0;
    a     = 4'd0;
    b     = 4'd0;

    vecs[0] = '{4'd15, 4'd15, 8'hE1};
    vecs[1] = '{4'd13, 4'd11, 8'h8F};
    vecs[2] = '{4'd0,  4'd9,  8'h00};
    vecs[3] = '{4'd3,  4'd5,  8'h0F};
    vecs[4] = '{4'd7,  4'd6,  8'h2A};
    vecs[5] = '{4'd1,  4'd1,  8'h01};
    vecs[6] = '{4'd15, 4'd1,  8'h0F};
    vecs[7] = '{4'd8,  4'd2,  8'h10};
    vecs[8] = '{4'd10, 4'd0,  8'h00};
    vecs[9] = '{4'd9,  4'd14, 8'h7E};

    #12;
    chk("reset busy", {7'd0, busy}, 8'd0);
    chk("reset done", {7'd0, done}, 8'd0);
    chk("reset P", p, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_op(vecs[i].va, vecs[i].vb, vecs[i].exp_p);

    // start held high: back-to-back 3*5 then 7*6, accepts at E0 and E6
    @(negedge clk);
    start = 1'b1;
    a = 4'd3;
    b = 4'd5;
    dones = 0;
    tick();
    chk("held E0 busy", {7'd0, busy}, 8'd1);
    @(negedge clk);
    a = 4'd7;
    b = 4'd6;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (done) dones++;
      if (e == 4) begin
        chk("held P E4", p, 8'h0F);
        chk("held done E4", {7'd0, done}, 8'd1);
      end
      if (e == 5) chk("held busy E5", {7'd0, busy}, 8'd0);
      if (e == 6) chk("held busy E6", {7'd0, busy}, 8'd1);
      if (e == 9) chk("held P E9", p, 8'h0F);
      if (e == 10) begin
        chk("held P E10", p, 8'h2A);
        chk("held done E10", {7'd0, done}, 8'd1);
      end
    end
    @(negedge clk);
    start = 1'b0;
    tick();
    chk("held done count", 8'(dones), 8'd2);

    // start during RUN is ignored
    @(negedge clk);
    start = 1'b1;
    a = 4'd9;
    b = 4'd7;
    tick();
    @(negedge clk);
    start = 1'b0;
    tick();
    @(negedge clk);
    start = 1'b1;
    a = 4'd15;
    b = 4'd15;
    for (int e = 2; e <= 5; e++) begin
      tick();
      if (e == 4) begin
        chk("ignore P E4", p, 8'h3F);
        chk("ignore done E4", {7'd0, done}, 8'd1);
      end
      if (e == 5) chk("ignore busy E5", {7'd0, busy}, 8'd0);
    end
    @(negedge clk);
    start = 1'b0;
    tick();
    chk("ignore busy E6", {7'd0, busy}, 8'd0);
    chk("ignore P E6", p, 8'h3F);

    // asynchronous reset mid-RUN aborts
    @(negedge clk);
    start = 1'b1;
    a = 4'd12;
    b = 4'd12;
    tick();
    @(negedge clk);
    start = 1'b0;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("abort busy", {7'd0, busy}, 8'd0);
    chk("abort done", {7'd0, done}, 8'd0);
    chk("abort P", p, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int e = 0; e < 6; e++) begin
      tick();
      if (done || busy) dones++;
    end
    chk("abort no activity", 8'(dones), 8'd0);
    chk("abort P after", p, 8'h00);
    run_op(4'd2, 4'd3, 8'h06);

    // exhaustive sweep
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        run_op(4'(i), 4'(j), 8'(i * j));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

`default_nettype wire
